// File: rtl/sha3_round_scheduler_if.sv
// Bus between the Keccak round sequencer, the hashing front end and the external round pipeline.
// slave is the sequencer side; master is the environment (front end plus round datapath).
interface sha3_round_scheduler_if;
    logic                  sample;
    logic [4:0][63:0]      isa, isb, isc, isd, ise;
    logic                  ready;
    logic [4:0][63:0]      rsa, rsb, rsc, rsd, rse;
    logic                  rsample;
    logic [4:0]            rround;
    logic                  rgood;
    logic [4:0][63:0]      rra, rrb, rrc, rrd, rre;
    logic [4:0][63:0]      osa, osb, osc, osd, ose;
    logic                  ogood;
    logic                  err;

    modport slave (
        input  sample, isa, isb, isc, isd, ise,
        input  rgood, rra, rrb, rrc, rrd, rre,
        output ready, rsa, rsb, rsc, rsd, rse, rsample, rround,
        output osa, osb, osc, osd, ose, ogood, err
    );

    modport master (
        output sample, isa, isb, isc, isd, ise,
        output rgood, rra, rrb, rrc, rrd, rre,
        input  ready, rsa, rsb, rsc, rsd, rse, rsample, rround,
        input  osa, osb, osc, osd, ose, ogood, err
    );
endinterface

// File: rtl/sha3_round_scheduler.sv
// Iterative Keccak-f[1600] sequencer: recirculates one state through an external fixed-latency
// round pipeline ROUNDS times, with watchdog checks and a post-reset drain of that pipeline.
module sha3_round_scheduler #(
    parameter int ROUND_LATENCY = 4,
    parameter int ROUNDS        = 24
) (
    input logic                   clk,
    input logic                   rst,
    sha3_round_scheduler_if.slave bus
);
    localparam int WDW = $clog2(ROUND_LATENCY + 2);
    localparam logic [WDW-1:0] WD_LAST    = WDW'(ROUND_LATENCY);
    localparam logic [WDW-1:0] DRAIN_LAST = WDW'(ROUND_LATENCY - 1);
    localparam logic [4:0]     RND_LAST   = 5'(ROUNDS - 1);

    generate
        if (ROUND_LATENCY < 1) begin : g_bad_latency
            $error("sha3_round_scheduler: ROUND_LATENCY must be >= 1");
        end
        if (ROUNDS < 1 || ROUNDS > 32) begin : g_bad_rounds
            $error("sha3_round_scheduler: ROUNDS must be in 1..32");
        end
    endgenerate

    typedef enum logic [2:0] {DRAIN, IDLE, ISSUE, WAIT, DONE} state_t;
    // Row index is y (a..e), lane index is x.
    typedef logic [4:0][4:0][63:0] st_t;

    state_t         state, state_n;
    st_t            st, in_st, rr_st;
    logic [4:0]     rnd, rnd_n;
    logic [WDW-1:0] wd, wd_n;
    logic           ld_in, ld_rr, err_set;
    logic           ready_q, rsample_q, ogood_q, err_q;

    assign in_st = {bus.ise, bus.isd, bus.isc, bus.isb, bus.isa};
    assign rr_st = {bus.rre, bus.rrd, bus.rrc, bus.rrb, bus.rra};

    assign bus.rsa = st[0];
    assign bus.rsb = st[1];
    assign bus.rsc = st[2];
    assign bus.rsd = st[3];
    assign bus.rse = st[4];
    assign bus.osa = st[0];
    assign bus.osb = st[1];
    assign bus.osc = st[2];
    assign bus.osd = st[3];
    assign bus.ose = st[4];

    assign bus.ready   = ready_q;
    assign bus.rsample = rsample_q;
    assign bus.ogood   = ogood_q;
    assign bus.rround  = rnd;
    assign bus.err     = err_q;

    always_ff @(posedge clk) begin
        if (rst) state <= DRAIN;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        rnd_n   = rnd;
        wd_n    = wd;
        ld_in   = 1'b0;
        ld_rr   = 1'b0;
        err_set = 1'b0;
        case (state)
            // wd doubles as the drain timer; rgood here belongs to pre-reset passes.
            DRAIN: begin
                if (wd == DRAIN_LAST) begin
                    state_n = IDLE;
                    wd_n    = '0;
                end else begin
                    wd_n = wd + 1'b1;
                end
            end
            IDLE: begin
                if (bus.rgood) err_set = 1'b1;
                if (bus.sample) begin
                    ld_in   = 1'b1;
                    rnd_n   = '0;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.rgood) err_set = 1'b1;
                wd_n    = WDW'(1);
                state_n = WAIT;
            end
            WAIT: begin
                if (bus.rgood && wd == WD_LAST) begin
                    ld_rr = 1'b1;
                    if (rnd == RND_LAST) begin
                        state_n = DONE;
                    end else begin
                        rnd_n   = rnd + 5'd1;
                        state_n = ISSUE;
                    end
                end else if (bus.rgood || wd == WD_LAST) begin
                    err_set = 1'b1;
                    state_n = IDLE;
                end else begin
                    wd_n = wd + 1'b1;
                end
            end
            DONE: begin
                if (bus.rgood) err_set = 1'b1;
                if (bus.sample) begin
                    ld_in   = 1'b1;
                    rnd_n   = '0;
                    state_n = ISSUE;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = DRAIN;
        endcase
    end

    // Strobes are registered from the next state so they line up with the state they qualify.
    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= '0;
            rnd       <= '0;
            wd        <= '0;
            err_q     <= 1'b0;
            ready_q   <= 1'b0;
            rsample_q <= 1'b0;
            ogood_q   <= 1'b0;
        end else begin
            if (ld_in)      st <= in_st;
            else if (ld_rr) st <= rr_st;
            rnd       <= rnd_n;
            wd        <= wd_n;
            err_q     <= err_q | err_set;
            ready_q   <= (state_n == IDLE) || (state_n == DONE);
            rsample_q <= (state_n == ISSUE);
            ogood_q   <= (state_n == DONE);
        end
    end
endmodule
